// File: rtl/mem_map_pkg.sv
// -----------------------------------------------------------------------------
// mem_map_pkg
// Address map shared by the RAM responder: the I/O window select field, the
// register offsets inside the window and the layout of the status byte.
// -----------------------------------------------------------------------------
package mem_map_pkg;

    // I/O window: ram_addr[IO_SEL_HI:IO_SEL_LO] == IO_SEL_VAL selects 0x30000-0x3FFFF.
    localparam int         IO_SEL_HI  = 17;
    localparam int         IO_SEL_LO  = 16;
    localparam logic [1:0] IO_SEL_VAL = 2'b11;

    // Register offsets, decoded from ram_addr[2:0].
    localparam logic [2:0] IO_TX_OFF   = 3'd0;
    localparam logic [2:0] IO_STAT_OFF = 3'd4;

    // Status byte bit positions.
    localparam int STAT_FULL_BIT = 0;
    localparam int STAT_OVF_BIT  = 1;

    // Assemble the status byte returned by a STAT read.
    function automatic logic [7:0] stat_byte(input logic overflow, input logic full);
        logic [7:0] s;
        s                = 8'h00;
        s[STAT_OVF_BIT]  = overflow;
        s[STAT_FULL_BIT] = full;
        return s;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
// Byte-wide FIFO with first-word-fall-through output. Pointers carry one extra
// wrap bit so full and empty come straight from a pointer compare.
//
// Ports:
//   clk            in   system clock
//   rst            in   synchronous active-high reset (empties the FIFO)
//   push           in   write din this cycle
//   din            in   [7:0] byte to write
//   pop            in   consume the head byte this cycle (ignored when empty)
//   dout           out  [7:0] head byte, combinational
//   empty          out  no bytes stored
//   full           out  DEPTH bytes stored
//   overflow_pulse out  a push was dropped this cycle (full and no pop)
// -----------------------------------------------------------------------------
module byte_fifo #(
    parameter int DEPTH = 8     // power of 2, at least 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full,
    output logic       overflow_pulse
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic        do_pop;
    logic        do_push;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_pop         = pop && !empty;
    assign do_push        = push && (!full || do_pop);
    assign overflow_pulse = push && full && !do_pop;

    assign dout = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage arrays are not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (!rst && do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ram_responder.sv
// -----------------------------------------------------------------------------
// ram_responder
// Memory-side responder for the byte-wide LSB RAM port. Serves one byte read
// or write per cycle into on-chip RAM and decodes a small I/O window holding
// a TX byte FIFO, a status register and a halt register.
//
// Ports:
//   clk             in   system clock
//   rst             in   synchronous active-high reset
//   ram_addr        in   [31:0] byte address (bits 31:18 ignored)
//   ram_writing     in   1 = write ram_data this cycle, 0 = read
//   ram_data        in   [7:0] write byte
//   ram_loaded_data out  [7:0] registered read byte (1-cycle latency)
//   io_tx_data      out  [7:0] TX FIFO head byte
//   io_tx_valid     out  TX FIFO not empty
//   io_tx_ready     in   sink accepts the head byte
//   io_overflow     out  sticky: a TX byte was dropped on a full FIFO
//   sim_halt        out  sticky: the halt register was written
// -----------------------------------------------------------------------------
module ram_responder
    import mem_map_pkg::*;
#(
    parameter int RAM_AW     = 17,
    parameter int FIFO_DEPTH = 8,
    parameter     INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ram_addr,
    input  logic        ram_writing,
    input  logic [7:0]  ram_data,
    output logic [7:0]  ram_loaded_data,
    output logic [7:0]  io_tx_data,
    output logic        io_tx_valid,
    input  logic        io_tx_ready,
    output logic        io_overflow,
    output logic        sim_halt
);

    localparam int RAM_DEPTH = 1 << RAM_AW;

    logic [7:0]        ram_q [RAM_DEPTH];
    logic [7:0]        loaded_q, loaded_d;
    logic              overflow_q, overflow_d;
    logic              halt_q, halt_d;

    logic              io_sel;
    logic [2:0]        io_off;
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_we;
    logic              tx_push;
    logic              halt_set;
    logic              tx_empty;
    logic              tx_full;
    logic              tx_ovf_pulse;
    logic              unused_addr_bits;

    // Upper address bits take no part in decoding.
    assign unused_addr_bits = ^ram_addr[31:IO_SEL_HI+1];

    assign io_sel  = (ram_addr[IO_SEL_HI:IO_SEL_LO] == IO_SEL_VAL);
    assign io_off  = ram_addr[2:0];
    assign ram_idx = ram_addr[RAM_AW-1:0];

    assign ram_we   = !rst && ram_writing && !io_sel;
    assign tx_push  = !rst && ram_writing && io_sel && (io_off == IO_TX_OFF);
    assign halt_set = ram_writing && io_sel && (io_off == IO_STAT_OFF);

    always_ff @(posedge clk) begin
        if (ram_we) ram_q[ram_idx] <= ram_data;
    end

    byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_tx_fifo (
        .clk           (clk),
        .rst           (rst),
        .push          (tx_push),
        .din           (ram_data),
        .pop           (io_tx_ready),
        .dout          (io_tx_data),
        .empty         (tx_empty),
        .full          (tx_full),
        .overflow_pulse(tx_ovf_pulse)
    );

    // Read mux samples the pre-update state, so a write cycle returns the old
    // RAM byte and a STAT read ignores a push in the same cycle.
    always_comb begin
        loaded_d   = 8'h00;
        overflow_d = overflow_q | tx_ovf_pulse;
        halt_d     = halt_q | halt_set;
        if (io_sel) begin
            if (io_off == IO_STAT_OFF) loaded_d = stat_byte(overflow_q, tx_full);
        end else begin
            loaded_d = ram_q[ram_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            loaded_q   <= 8'h00;
            overflow_q <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            loaded_q   <= loaded_d;
            overflow_q <= overflow_d;
            halt_q     <= halt_d;
        end
    end

    assign ram_loaded_data = loaded_q;
    assign io_tx_valid     = !tx_empty;
    assign io_overflow     = overflow_q;
    assign sim_halt        = halt_q;

endmodule

// File: tb/tb_ram_responder.sv
// -----------------------------------------------------------------------------
// tb_ram_responder
// Directed bench for ram_responder. A transaction-level model (associative
// byte memory, byte queue for the TX FIFO, two sticky flags) tracks expected
// outputs and is compared every cycle; directed steps add literal checks.
// -----------------------------------------------------------------------------
module tb_ram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ram_addr;
    logic        ram_writing;
    logic [7:0]  ram_data;
    logic [7:0]  ram_loaded_data;
    logic [7:0]  io_tx_data;
    logic        io_tx_valid;
    logic        io_tx_ready;
    logic        io_overflow;
    logic        sim_halt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ram_responder #(
        .RAM_AW    (17),
        .FIFO_DEPTH(8),
        .INIT_FILE ("")
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ram_addr       (ram_addr),
        .ram_writing    (ram_writing),
        .ram_data       (ram_data),
        .ram_loaded_data(ram_loaded_data),
        .io_tx_data     (io_tx_data),
        .io_tx_valid    (io_tx_valid),
        .io_tx_ready    (io_tx_ready),
        .io_overflow    (io_overflow),
        .sim_halt       (sim_halt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_mem [int];
    logic [7:0] m_q [$];
    logic [7:0] m_loaded = 8'h00;
    bit         m_known  = 1'b0;
    bit         m_ovf    = 1'b0;
    bit         m_halt   = 1'b0;
    bit         m_live   = 1'b0;

    task automatic model_step();
        bit         io;
        int         idx;
        bit         was_full;
        bit         popped;
        io  = (ram_addr[17:16] == 2'b11);
        idx = int'(ram_addr[16:0]);
        if (rst) begin
            m_live   = 1'b1;
            m_loaded = 8'h00;
            m_known  = 1'b1;
            m_q.delete();
            m_ovf    = 1'b0;
            m_halt   = 1'b0;
        end else if (m_live) begin
            was_full = (m_q.size() == 8);
            m_known  = 1'b1;
            if (io) begin
                m_loaded = (ram_addr[2:0] == 3'd4) ? {6'b0, m_ovf, was_full} : 8'h00;
            end else if (m_mem.exists(idx)) begin
                m_loaded = m_mem[idx];
            end else begin
                m_known = 1'b0;
            end
            popped = io_tx_ready && (m_q.size() > 0);
            if (popped) void'(m_q.pop_front());
            if (ram_writing && io && ram_addr[2:0] == 3'd0) begin
                if (!was_full || popped) m_q.push_back(ram_data);
                else m_ovf = 1'b1;
            end
            if (ram_writing && io && ram_addr[2:0] == 3'd4) m_halt = 1'b1;
            if (ram_writing && !io) m_mem[idx] = ram_data;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_live) begin
            if (m_known) check("model.loaded", ram_loaded_data, m_loaded);
            check("model.valid", io_tx_valid, m_q.size() != 0);
            if (m_q.size() != 0) check("model.head", io_tx_data, m_q[0]);
            check("model.overflow", io_overflow, m_ovf);
            check("model.halt", sim_halt, m_halt);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] a, input logic w, input logic [7:0] d);
        ram_addr    = a;
        ram_writing = w;
        ram_data    = d;
    endtask

    initial begin
        logic [7:0] exp_e [8];
        exp_e = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h77};

        rst         = 1'b1;
        io_tx_ready = 1'b0;
        put(32'h0, 1'b0, 8'h00);
        step();
        step();
        check("reset.loaded", ram_loaded_data, 8'h00);
        check("reset.valid", io_tx_valid, 1'b0);
        check("reset.overflow", io_overflow, 1'b0);
        check("reset.halt", sim_halt, 1'b0);
        rst = 1'b0;

        // Read-first write, then read-after-write.
        put(32'h0000_0010, 1'b1, 8'h3C); step();
        put(32'h0000_0010, 1'b1, 8'hA5); step();
        check("rw.read_first", ram_loaded_data, 8'h3C);
        put(32'h0000_0010, 1'b0, 8'h00); step();
        check("rw.after_write", ram_loaded_data, 8'hA5);
        put(32'hFFF0_0010, 1'b0, 8'h00); step();
        check("rw.upper_bits_ignored", ram_loaded_data, 8'hA5);

        // Back-to-back reads in issue order.
        put(32'h100, 1'b1, 8'h13); step();
        put(32'h101, 1'b1, 8'h05); step();
        put(32'h102, 1'b1, 8'h00); step();
        put(32'h103, 1'b1, 8'h00); step();
        put(32'h103, 1'b0, 8'h00); step();
        check("b2b.0x103", ram_loaded_data, 8'h00);
        put(32'h102, 1'b0, 8'h00); step();
        check("b2b.0x102", ram_loaded_data, 8'h00);
        put(32'h101, 1'b0, 8'h00); step();
        check("b2b.0x101", ram_loaded_data, 8'h05);
        put(32'h100, 1'b0, 8'h00); step();
        check("b2b.0x100", ram_loaded_data, 8'h13);

        // TX with ready held high.
        io_tx_ready = 1'b1;
        put(32'h3_0000, 1'b1, 8'h48); step();
        check("tx.valid0", io_tx_valid, 1'b1);
        check("tx.data0", io_tx_data, 8'h48);
        put(32'h3_0000, 1'b1, 8'h69); step();
        check("tx.valid1", io_tx_valid, 1'b1);
        check("tx.data1", io_tx_data, 8'h69);
        put(32'h10, 1'b0, 8'h00); step();
        check("tx.drained", io_tx_valid, 1'b0);

        // Overflow: nine pushes into eight slots.
        io_tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            put(32'h3_0000, 1'b1, i[7:0]);
            step();
        end
        check("ovf.flag", io_overflow, 1'b1);
        put(32'h3_0004, 1'b0, 8'h00); step();
        check("ovf.status", ram_loaded_data, 8'h03);
        put(32'h10, 1'b0, 8'h00);
        io_tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("ovf.drain_valid", io_tx_valid, 1'b1);
            check("ovf.drain_data", io_tx_data, i[7:0]);
            step();
        end
        check("ovf.empty", io_tx_valid, 1'b0);
        check("ovf.sticky", io_overflow, 1'b1);

        // Push into a full FIFO with a simultaneous pop.
        rst = 1'b1; step(); rst = 1'b0;
        check("full_pop.ovf_cleared", io_overflow, 1'b0);
        io_tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            put(32'h3_0000, 1'b1, 8'h11 + i[7:0]);
            step();
        end
        io_tx_ready = 1'b1;
        put(32'h3_0000, 1'b1, 8'h77); step();
        check("full_pop.no_ovf", io_overflow, 1'b0);
        io_tx_ready = 1'b0;
        put(32'h3_0004, 1'b0, 8'h00); step();
        check("full_pop.still_full", ram_loaded_data, 8'h01);
        io_tx_ready = 1'b1;
        put(32'h10, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            check("full_pop.drain_valid", io_tx_valid, 1'b1);
            check("full_pop.drain_data", io_tx_data, exp_e[i]);
            step();
        end
        check("full_pop.empty", io_tx_valid, 1'b0);
        put(32'h3_0004, 1'b1, 8'hFF); step();
        check("halt.set", sim_halt, 1'b1);

        // Reset mid-activity; a write during reset is ignored.
        io_tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(32'h3_0000, 1'b1, 8'h21 + i[7:0]);
            step();
        end
        put(32'h100, 1'b0, 8'h00); step();
        check("rst.pre_loaded", ram_loaded_data, 8'h13);
        rst = 1'b1;
        put(32'h10, 1'b1, 8'hEE); step();
        check("rst.valid", io_tx_valid, 1'b0);
        check("rst.loaded", ram_loaded_data, 8'h00);
        check("rst.overflow", io_overflow, 1'b0);
        check("rst.halt", sim_halt, 1'b0);
        rst = 1'b0;
        put(32'h10, 1'b0, 8'h00); step();
        check("rst.ram_kept_0x10", ram_loaded_data, 8'hA5);
        put(32'h100, 1'b0, 8'h00); step();
        check("rst.ram_kept_0x100", ram_loaded_data, 8'h13);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
